// File: rtl/eq_run_pkg.sv
// Shared definitions for the equal-run detector.
//   state_t        : detector FSM states (IDLE / RUN / HIT)
//   DEF_W          : default compared word width
//   DEF_RUN_LEN    : default number of consecutive equal samples for a hit
//   HIT_TOTAL_MAX  : saturation value of the 16-bit hit counter
package eq_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2
  } state_t;

  localparam int unsigned DEF_W         = 8;
  localparam int unsigned DEF_RUN_LEN   = 4;
  localparam logic [15:0] HIT_TOTAL_MAX = 16'hFFFF;

endpackage

// File: rtl/eq_n.sv
// Purely combinational W-bit equality comparator.
//   a, b : words to compare
//   eq   : 1 when all W bits of a and b match
// Built from one 1-bit equality cell per bit, AND-reduced.

module eq_cell (
  input  logic a,
  input  logic b,
  output logic eq
);

  assign eq = ~(a ^ b);

endmodule

module eq_n #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq
);

  logic [W-1:0] bit_eq;

  for (genvar i = 0; i < int'(W); i++) begin : g_bit
    eq_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .eq (bit_eq[i])
    );
  end

  assign eq = &bit_eq;

endmodule

// File: rtl/eq_run_detector.sv
// Equal-run detector: counts consecutive accepted samples equal to a
// loaded reference word and pulses hit when RUN_LEN of them are seen.
//   clk, reset : clock, asynchronous active-high reset
//   ref_load   : latch ref_in as reference (priority over samples)
//   ref_in     : reference word
//   in_valid   : sample presented on in_data
//   in_data    : sample word
//   in_ready   : sample accepted when in_valid && in_ready
//   eq         : registered equality of the last accepted sample
//   run_cnt    : consecutive equal accepted samples
//   hit        : one-cycle pulse after the RUN_LEN-th equal sample
//   hit_total  : saturating count of hits since reset

module eq_run_detector
  import eq_run_pkg::*;
#(
  parameter int unsigned W       = DEF_W,
  parameter int unsigned RUN_LEN = DEF_RUN_LEN
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ref_load,
  input  logic [W-1:0] ref_in,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         eq,
  output logic [7:0]   run_cnt,
  output logic         hit,
  output logic [15:0]  hit_total
);

  localparam logic [7:0] RUN_LEN_C = 8'(RUN_LEN);

  state_t       state_q, state_d;
  logic [W-1:0] ref_q;
  logic         eq_q;
  logic [7:0]   run_cnt_q;
  logic [15:0]  hit_total_q;

  logic         match;
  logic         accept;
  logic [7:0]   cnt_inc;

  eq_n #(.W(W)) u_eq (
    .a  (in_data),
    .b  (ref_q),
    .eq (match)
  );

  assign accept  = in_valid && in_ready;
  assign cnt_inc = run_cnt_q + 8'd1;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (ref_load) state_d = ST_RUN;
      ST_RUN: begin
        if (ref_load)                                     state_d = ST_RUN;
        else if (accept && match && cnt_inc == RUN_LEN_C) state_d = ST_HIT;
      end
      ST_HIT:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = (state_q == ST_RUN) && !ref_load;
    hit      = (state_q == ST_HIT);
  end

  // Datapath registers. A hit is counted even when ref_load arrives in
  // the HIT cycle, since the pulse is still presented on hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_q       <= '0;
      eq_q        <= 1'b0;
      run_cnt_q   <= '0;
      hit_total_q <= '0;
    end else begin
      if (state_q == ST_HIT && hit_total_q != HIT_TOTAL_MAX)
        hit_total_q <= hit_total_q + 16'd1;

      if (ref_load) begin
        ref_q     <= ref_in;
        run_cnt_q <= '0;
        eq_q      <= 1'b0;
      end else if (state_q == ST_HIT) begin
        run_cnt_q <= '0;
      end else if (accept) begin
        if (match) begin
          eq_q      <= 1'b1;
          run_cnt_q <= cnt_inc;
        end else begin
          eq_q      <= 1'b0;
          run_cnt_q <= '0;
        end
      end
    end
  end

  assign eq        = eq_q;
  assign run_cnt   = run_cnt_q;
  assign hit_total = hit_total_q;

endmodule

// File: tb/tb_eq_run_detector.sv
module tb_eq_run_detector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ref_load = 1'b0;
  logic [7:0]  ref_in = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        eq;
  logic [7:0]  run_cnt;
  logic        hit;
  logic [15:0] hit_total;

  eq_run_detector #(.W(8), .RUN_LEN(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .ref_load  (ref_load),
    .ref_in    (ref_in),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .eq        (eq),
    .run_cnt   (run_cnt),
    .hit       (hit),
    .hit_total (hit_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          row;
    logic        rdy;
    logic        eqv;
    logic [7:0]  cnt;
    logic        hitv;
    logic [15:0] tot;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   row_no = 0;

  task automatic check(input string name, input int row, input logic [15:0] act,
                       input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL row %0d %s: got %h expected %h", row, name, act, req);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, after the driver has set this
  // cycle's inputs, and compared against the expectation queued for it.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("in_ready",  e.row, 16'(in_ready),  16'(e.rdy));
      check("eq",        e.row, 16'(eq),        16'(e.eqv));
      check("run_cnt",   e.row, 16'(run_cnt),   16'(e.cnt));
      check("hit",       e.row, 16'(hit),       16'(e.hitv));
      check("hit_total", e.row, hit_total,      e.tot);
    end
  end

  // One cycle of stimulus plus the outputs expected during that cycle.
  task automatic step(input logic rst, input logic ld, input logic [7:0] rin,
                      input logic v, input logic [7:0] d,
                      input logic e_rdy, input logic e_eq, input logic [7:0] e_cnt,
                      input logic e_hit, input logic [15:0] e_tot);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = rst;
    ref_load = ld;
    ref_in   = rin;
    in_valid = v;
    in_data  = d;
    e.row  = row_no;
    e.rdy  = e_rdy;
    e.eqv  = e_eq;
    e.cnt  = e_cnt;
    e.hitv = e_hit;
    e.tot  = e_tot;
    exp_q.push_back(e);
    row_no++;
  endtask

  initial begin
    //    rst ld rin    v  d      rdy eq cnt hit tot
    // reset, then samples without a reference are ignored
    step(1, 0, 8'h00, 0, 8'h00,  0, 0, 0, 0, 16'd0);
    step(0, 0, 8'h00, 1, 8'h00,  0, 0, 0, 0, 16'd0);
    step(0, 0, 8'h00, 1, 8'h00,  0, 0, 0, 0, 16'd0);
    // reference A5, four equal samples -> hit
    step(0, 1, 8'hA5, 0, 8'h00,  0, 0, 0, 0, 16'd0);
    step(0, 0, 8'h00, 1, 8'hA5,  1, 0, 0, 0, 16'd0);
    step(0, 0, 8'h00, 1, 8'hA5,  1, 1, 1, 0, 16'd0);
    step(0, 0, 8'h00, 1, 8'hA5,  1, 1, 2, 0, 16'd0);
    step(0, 0, 8'h00, 1, 8'hA5,  1, 1, 3, 0, 16'd0);
    step(0, 0, 8'h00, 1, 8'hA5,  0, 1, 4, 1, 16'd0);
    step(0, 0, 8'h00, 0, 8'h00,  1, 1, 0, 0, 16'd1);
    // A5, gap, A5, A4, A5 -> eq 1,1,0,1 cnt 1,2,0,1
    step(0, 0, 8'h00, 1, 8'hA5,  1, 1, 0, 0, 16'd1);
    step(0, 0, 8'h00, 0, 8'h00,  1, 1, 1, 0, 16'd1);
    step(0, 0, 8'h00, 1, 8'hA5,  1, 1, 1, 0, 16'd1);
    step(0, 0, 8'h00, 1, 8'hA4,  1, 1, 2, 0, 16'd1);
    step(0, 0, 8'h00, 1, 8'hA5,  1, 0, 0, 0, 16'd1);
    step(0, 0, 8'h00, 0, 8'h00,  1, 1, 1, 0, 16'd1);
    // reference 3C, run of 3, then ref_load with a valid sample
    step(0, 1, 8'h3C, 0, 8'h00,  0, 1, 1, 0, 16'd1);
    step(0, 0, 8'h00, 1, 8'h3C,  1, 0, 0, 0, 16'd1);
    step(0, 0, 8'h00, 1, 8'h3C,  1, 1, 1, 0, 16'd1);
    step(0, 0, 8'h00, 1, 8'h3C,  1, 1, 2, 0, 16'd1);
    step(0, 1, 8'h3C, 1, 8'h3C,  0, 1, 3, 0, 16'd1);
    // full-width compare: MSB and LSB differences both break the run
    step(0, 0, 8'h00, 1, 8'h3C,  1, 0, 0, 0, 16'd1);
    step(0, 0, 8'h00, 1, 8'hBC,  1, 1, 1, 0, 16'd1);
    step(0, 0, 8'h00, 1, 8'h3C,  1, 0, 0, 0, 16'd1);
    step(0, 0, 8'h00, 1, 8'h3D,  1, 1, 1, 0, 16'd1);
    step(0, 0, 8'h00, 0, 8'h00,  1, 0, 0, 0, 16'd1);
    // run to HIT, ref_load during HIT still counts that hit
    step(0, 0, 8'h00, 1, 8'h3C,  1, 0, 0, 0, 16'd1);
    step(0, 0, 8'h00, 1, 8'h3C,  1, 1, 1, 0, 16'd1);
    step(0, 0, 8'h00, 1, 8'h3C,  1, 1, 2, 0, 16'd1);
    step(0, 0, 8'h00, 1, 8'h3C,  1, 1, 3, 0, 16'd1);
    step(0, 1, 8'h01, 1, 8'h3C,  0, 1, 4, 1, 16'd1);
    step(0, 0, 8'h00, 0, 8'h00,  1, 0, 0, 0, 16'd2);
    // reference 01, two equal samples, asynchronous reset mid-cycle
    step(0, 0, 8'h00, 1, 8'h01,  1, 0, 0, 0, 16'd2);
    step(0, 0, 8'h00, 1, 8'h01,  1, 1, 1, 0, 16'd2);
    step(1, 0, 8'h00, 1, 8'h01,  0, 0, 0, 0, 16'd0);
    step(0, 0, 8'h00, 1, 8'h01,  0, 0, 0, 0, 16'd0);
    step(0, 0, 8'h00, 1, 8'h01,  0, 0, 0, 0, 16'd0);
    // reset while in HIT drops the pulse
    step(0, 1, 8'h7E, 0, 8'h00,  0, 0, 0, 0, 16'd0);
    step(0, 0, 8'h00, 1, 8'h7E,  1, 0, 0, 0, 16'd0);
    step(0, 0, 8'h00, 1, 8'h7E,  1, 1, 1, 0, 16'd0);
    step(0, 0, 8'h00, 1, 8'h7E,  1, 1, 2, 0, 16'd0);
    step(0, 0, 8'h00, 1, 8'h7E,  1, 1, 3, 0, 16'd0);
    step(1, 0, 8'h00, 0, 8'h00,  0, 0, 0, 0, 16'd0);
    step(0, 0, 8'h00, 0, 8'h00,  0, 0, 0, 0, 16'd0);

    // Preload the hit counter near its ceiling instead of running 65534 hits.
    @(posedge clk);
    #1;
    force dut.hit_total_q = 16'hFFFE;
    #1;
    release dut.hit_total_q;
    // expectation for the idle cycle above is not queued; resume rows
    step(0, 1, 8'h55, 0, 8'h00,  0, 0, 0, 0, 16'hFFFE);
    step(0, 0, 8'h00, 1, 8'h55,  1, 0, 0, 0, 16'hFFFE);
    step(0, 0, 8'h00, 1, 8'h55,  1, 1, 1, 0, 16'hFFFE);
    step(0, 0, 8'h00, 1, 8'h55,  1, 1, 2, 0, 16'hFFFE);
    step(0, 0, 8'h00, 1, 8'h55,  1, 1, 3, 0, 16'hFFFE);
    step(0, 0, 8'h00, 0, 8'h00,  0, 1, 4, 1, 16'hFFFE);
    step(0, 0, 8'h00, 1, 8'h55,  1, 1, 0, 0, 16'hFFFF);
    step(0, 0, 8'h00, 1, 8'h55,  1, 1, 1, 0, 16'hFFFF);
    step(0, 0, 8'h00, 1, 8'h55,  1, 1, 2, 0, 16'hFFFF);
    step(0, 0, 8'h00, 1, 8'h55,  1, 1, 3, 0, 16'hFFFF);
    step(0, 0, 8'h00, 0, 8'h00,  0, 1, 4, 1, 16'hFFFF);
    step(0, 0, 8'h00, 0, 8'h00,  1, 1, 0, 0, 16'hFFFF);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eq_run_detector.md
EQ_RUN_DETECTOR -- requirements
Module: eq_run_detector

Interface
REQ-001 Parameter W, default 8: width of compared words.
REQ-002 Parameter RUN_LEN, default 4: consecutive equal samples that constitute a hit; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ref_load  input  1  latch ref_in as the new reference word this cycle.
REQ-006 ref_in  input  W  reference word.
REQ-007 in_valid  input  1  in_data is presented.
REQ-008 in_data  input  W  sample word to compare against the reference.
REQ-009 in_ready  output  1  block accepts a sample this cycle; transfer when in_valid && in_ready.
REQ-010 eq  output  1  registered equality result of the last accepted sample.
REQ-011 run_cnt  output  8  current count of consecutive equal accepted samples.
REQ-012 hit  output  1  one-cycle pulse: RUN_LEN consecutive equal samples reached.
REQ-013 hit_total  output  16  number of hits since reset, saturating.

Function
REQ-014 FSM states SHALL be IDLE (no reference held), RUN (comparing) and HIT (reporting).
REQ-015 IDLE: in_ready=0; ref_load=1 latches ref_in, clears run_cnt, next state RUN.
REQ-016 RUN: in_ready = !ref_load; an accepted sample equal to the reference sets eq=1 and increments run_cnt.
REQ-017 RUN: an accepted sample unequal to the reference sets eq=0 and clears run_cnt to 0.
REQ-018 RUN: when an equal sample brings run_cnt to RUN_LEN, the next state is HIT and run_cnt shows RUN_LEN in that cycle.
REQ-019 HIT: hit=1 for exactly one cycle, in_ready=0, hit_total increments unless at 16'hFFFF, run_cnt clears to 0, next state RUN.
REQ-020 Latency: hit asserts in the cycle after the clock edge that accepted the RUN_LEN-th consecutive equal sample.
REQ-021 ref_load in RUN or HIT SHALL latch ref_in, clear run_cnt and eq, and go to RUN; it has priority over in_valid, and no sample is accepted in that cycle.
REQ-022 A cycle with in_valid=0 in RUN SHALL leave run_cnt and eq unchanged (gaps do not break a run).
REQ-023 Equality SHALL be full-width bitwise: all W bits equal.
REQ-024 hit_total SHALL saturate at 16'hFFFF; it is never cleared except by reset.
REQ-025 A run continuing past a hit restarts counting from 0; RUN_LEN=1 produces a hit for every equal sample (one per two cycles maximum).

Reset
REQ-026 reset=1 SHALL immediately force state IDLE, reference=0, in_ready=0, eq=0, run_cnt=0, hit=0, hit_total=0, regardless of clock.
REQ-027 Reset asserted mid-run or during HIT SHALL drop hit and discard the partial run; after release a ref_load is required before any sample is accepted.

Structure
REQ-028 A package eq_run_pkg SHALL hold the FSM state enum, the default W and RUN_LEN values, and the HIT_TOTAL_MAX constant.
REQ-029 The W-bit compare SHALL be a sub-module eq_n, built from per-bit 1-bit equality cells AND-reduced, purely combinational.
REQ-030 All registers SHALL live in eq_run_detector; no clock gating, no latches.

Verification
REQ-031 Reset then in_valid=1, in_data=8'h00 without ref_load -> in_ready=0, run_cnt=0, hit never asserts.
REQ-032 ref_load with ref_in=8'hA5, then four accepted 8'hA5 -> run_cnt 1,2,3,4, hit=1 one cycle later for exactly one cycle, hit_total=1.
REQ-033 ref 8'hA5; samples A5,A5,A4,A5 -> eq 1,1,0,1; run_cnt 1,2,0,1; no hit.
REQ-034 ref 8'h3C; A run of 3 equal samples, then ref_load=1 with in_valid=1 and ref_in=8'h3C -> in_ready=0 that cycle, run_cnt=0, the sample is not accepted.
REQ-035 ref 8'h01; two equal samples, then reset pulse between clock edges -> outputs zero immediately, state IDLE, hit_total=0.
REQ-036 Force hit_total to 16'hFFFF via 65535 hits (or a RUN_LEN=1 build) -> further hits pulse hit but hit_total stays 16'hFFFF.
